// File: rtl/icdt_pkg.sv
// Shared definitions for the ICDT two-pass 8x8 transform scheduler:
// FSM state encoding, transform size and index width.
package icdt_pkg;

    localparam int XFORM_N = 8;
    localparam int IDX_W   = 3;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFORM_N - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_IN = 3'd1,
        ST_PASS1   = 3'd2,
        ST_TURN    = 3'd3,
        ST_PASS2   = 3'd4
    } state_e;

    // True on the final (bottom-right) element of an 8x8 walk.
    function automatic logic is_corner(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j);
        return (i == IDX_LAST) && (j == IDX_LAST);
    endfunction

endpackage

// File: rtl/icdt_sched_if.sv
// Control/handshake bundle between the ICDT scheduler and its datapath,
// input block buffer and downstream consumer.
interface icdt_sched_if #(
    parameter int BLK_CNT_W = 6
);
    logic                        start;
    logic [BLK_CNT_W-1:0]        num_blocks;
    logic                        abort;
    logic                        in_valid;
    logic                        in_ack;
    logic                        out_ready;
    logic [icdt_pkg::IDX_W-1:0]  i_idx;
    logic [icdt_pkg::IDX_W-1:0]  j_idx;
    logic                        sel_src;
    logic                        sel_coef;
    logic                        wen_temp;
    logic                        wen_out;
    logic [BLK_CNT_W-1:0]        blk_idx;
    logic                        busy;
    logic                        done;

    modport slave (
        input  start, num_blocks, abort, in_valid, out_ready,
        output in_ack, i_idx, j_idx, sel_src, sel_coef, wen_temp, wen_out,
               blk_idx, busy, done
    );

    modport master (
        output start, num_blocks, abort, in_valid, out_ready,
        input  in_ack, i_idx, j_idx, sel_src, sel_coef, wen_temp, wen_out,
               blk_idx, busy, done
    );
endinterface

// File: rtl/icdt_idx_cnt.sv
// Row/column walker over an 8x8 block: j advances on enable and its 7->0
// wrap carries into i; clear has priority over enable.
module icdt_idx_cnt
    import icdt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [IDX_W-1:0] i_idx,
    output logic [IDX_W-1:0] j_idx,
    output logic             last
);

    logic [IDX_W-1:0] i_d, i_q;
    logic [IDX_W-1:0] j_d, j_q;
    logic             wrap_s;

    assign wrap_s = (j_q == IDX_LAST);

    // Next-index computation; the (7,7) step rolls both indices back to 0.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
        end else if (en) begin
            j_d = j_q + IDX_W'(1);
            if (wrap_s) begin
                i_d = i_q + IDX_W'(1);
            end else begin
                i_d = i_q;
            end
        end else begin
            i_d = i_q;
            j_d = j_q;
        end
    end

    // Index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign i_idx = i_q;
    assign j_idx = j_q;
    assign last  = is_corner(i_q, j_q);

endmodule

// File: rtl/icdt_sched.sv
// Scheduler for a two-pass 8x8 inverse transform: row pass into temp RAM,
// one turnaround cycle, then column pass to the output with back-pressure.
module icdt_sched
    import icdt_pkg::*;
#(
    parameter int BLK_CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    icdt_sched_if.slave bus
);

    state_e               state_d, state_q;
    logic                 armed_d, armed_q;
    logic [BLK_CNT_W-1:0] last_blk_d, last_blk_q;
    logic [BLK_CNT_W-1:0] blk_idx_d, blk_idx_q;
    logic                 done_d, done_q;
    logic                 idx_en_s;
    logic                 idx_clr_s;
    logic                 idx_last_s;
    logic [IDX_W-1:0]     i_s;
    logic [IDX_W-1:0]     j_s;

    icdt_idx_cnt u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (idx_en_s),
        .clr   (idx_clr_s),
        .i_idx (i_s),
        .j_idx (j_s),
        .last  (idx_last_s)
    );

    // State register; armed_q holds the FSM still for the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            last_blk_q <= '0;
            blk_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            last_blk_q <= last_blk_d;
            blk_idx_q  <= blk_idx_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; abort outranks every other transition.
    always_comb begin
        state_d    = state_q;
        armed_d    = 1'b1;
        last_blk_d = last_blk_q;
        blk_idx_d  = blk_idx_q;
        done_d     = 1'b0;
        idx_en_s   = 1'b0;
        idx_clr_s  = 1'b0;
        if (!armed_q) begin
            state_d = ST_IDLE;
        end else if (bus.abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            blk_idx_d = '0;
            idx_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        // A count of 0 wraps to all-ones, i.e. 2^BLK_CNT_W blocks.
                        last_blk_d = bus.num_blocks - BLK_CNT_W'(1);
                        blk_idx_d  = '0;
                        idx_clr_s  = 1'b1;
                        state_d    = ST_WAIT_IN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_IN: begin
                    if (bus.in_valid) begin
                        state_d = ST_PASS1;
                    end else begin
                        state_d = ST_WAIT_IN;
                    end
                end
                ST_PASS1: begin
                    idx_en_s = 1'b1;
                    if (idx_last_s) begin
                        state_d = ST_TURN;
                    end else begin
                        state_d = ST_PASS1;
                    end
                end
                ST_TURN: begin
                    state_d = ST_PASS2;
                end
                ST_PASS2: begin
                    idx_en_s = bus.out_ready;
                    if (bus.out_ready && idx_last_s) begin
                        if (blk_idx_q == last_blk_q) begin
                            state_d   = ST_IDLE;
                            done_d    = 1'b1;
                            blk_idx_d = '0;
                        end else begin
                            state_d   = ST_WAIT_IN;
                            blk_idx_d = blk_idx_q + BLK_CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_PASS2;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    idx_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Output decode from the current state; wen_out follows out_ready directly.
    always_comb begin
        bus.busy     = (state_q != ST_IDLE);
        bus.wen_temp = (state_q == ST_PASS1);
        bus.sel_src  = (state_q == ST_PASS2);
        bus.sel_coef = (state_q == ST_PASS2);
        bus.wen_out  = (state_q == ST_PASS2) && bus.out_ready;
        bus.in_ack   = (state_q == ST_PASS1) && idx_last_s && !bus.abort;
        bus.done     = done_q;
        bus.blk_idx  = blk_idx_q;
        bus.i_idx    = i_s;
        bus.j_idx    = j_s;
    end

endmodule

// File: tb/tb_icdt_sched.sv
// Randomized directed bench for icdt_sched: each run's timeline is planned
// as block intervals up front, and every cycle is compared against it.
module tb_icdt_sched;

    localparam int W    = 2;
    localparam int NMAX = 1 << W;
    localparam int MAXT = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icdt_sched_if #(.BLK_CNT_W(W)) bus ();
    icdt_sched #(.BLK_CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    bit iv_a [MAXT];
    bit rd_a [MAXT];
    bit st_a [MAXT];
    bit ab_a [MAXT];
    int ws_a  [NMAX];
    int p1_a  [NMAX];
    int p2s_a [NMAX];
    int p2e_a [NMAX];

    task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=0x%0h expected=0x%0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [12:0] obs_vec();
        return {bus.busy, bus.wen_temp, bus.wen_out, bus.sel_src, bus.sel_coef,
                bus.in_ack, bus.done, bus.i_idx, bus.j_idx};
    endfunction

    function automatic logic [12:0] mk(bit busy, bit wt, bit wo, bit sel, bit ack, bit dn, int i, int j);
        return {busy, wt, wo, sel, sel, ack, dn, 3'(i), 3'(j)};
    endfunction

    // Expected outputs at cycle t of the planned run, located by block interval.
    function automatic void expect_at(input int t, input int nblk, input int done_t,
                                      output logic [12:0] e, output int eb);
        int k;
        e  = '0;
        eb = 0;
        if (t == done_t) e = mk(0, 0, 0, 0, 0, 1, 0, 0);
        for (int b = 0; b < nblk; b++) begin
            if (t >= ws_a[b] && t <= p2e_a[b]) begin
                eb = b;
                if (t < p1_a[b]) begin
                    e = mk(1, 0, 0, 0, 0, 0, 0, 0);
                end else if (t < p1_a[b] + 64) begin
                    k = t - p1_a[b];
                    e = mk(1, 1, 0, 0, k == 63, 0, k / 8, k % 8);
                end else if (t == p1_a[b] + 64) begin
                    e = mk(1, 0, 0, 0, 0, 0, 0, 0);
                end else begin
                    k = 0;
                    for (int u = p2s_a[b]; u < t; u++) k += int'(rd_a[u]);
                    e = mk(1, 0, rd_a[t], 1, 0, 0, k / 8, k % 8);
                end
            end
        end
    endfunction

    // Release reset with start held high; the first edge must not move the FSM.
    task automatic reset_release();
        bus.start      = 1'b1;
        bus.num_blocks = W'(1);
        bus.abort      = 1'b0;
        rst_n          = 1'b1;
        @(posedge clk);
        #1;
        #1;
        chk("first_edge_hold", -1, obs_vec(), 13'd0);
    endtask

    task automatic run(input int nb, input int stall_blk, input int stall_len, input int rmode,
                       input int abort_blk, input int abort_k, input int rst_k);
        int nblk, t, cnt, s, done_t, end_t, t_ab, t_rst, nwt, nwo, eb;
        logic [12:0] e;
        nblk  = (nb == 0) ? NMAX : nb;
        t_ab  = -1;
        t_rst = -1;
        for (int k = 0; k < MAXT; k++) begin
            iv_a[k] = bit'($urandom_range(1));
            rd_a[k] = bit'($urandom_range(1));
            st_a[k] = bit'($urandom_range(1));
            ab_a[k] = 1'b0;
        end
        t = 1;
        for (int b = 0; b < nblk; b++) begin
            s = (b == stall_blk) ? stall_len : 0;
            ws_a[b] = t;
            for (int k = 0; k < s; k++) iv_a[t + k] = 1'b0;
            iv_a[t + s] = 1'b1;
            p1_a[b] = t + s + 1;
            if (b == 0 && rst_k >= 0) t_rst = p1_a[b] + rst_k;
            t = p1_a[b] + 65;
            p2s_a[b] = t;
            cnt = 0;
            while (cnt < 64) begin
                if (rmode == 0) rd_a[t] = 1'b1;
                else if (rmode == 1) rd_a[t] = bit'((t - p2s_a[b]) % 2);
                if (b == abort_blk && cnt == abort_k && t_ab < 0) t_ab = t;
                if (rd_a[t]) cnt++;
                t++;
            end
            p2e_a[b] = t - 1;
        end
        done_t  = t;
        st_a[0] = 1'b1;
        st_a[done_t] = 1'b0;
        end_t = done_t;
        if (t_ab >= 0) begin
            end_t = t_ab;
            ab_a[t_ab] = 1'b1;
        end
        if (t_rst >= 0) end_t = t_rst;
        nwt = 0;
        nwo = 0;
        for (int t2 = 0; t2 <= end_t; t2++) begin
            bus.start      = st_a[t2];
            bus.abort      = ab_a[t2];
            bus.in_valid   = iv_a[t2];
            bus.out_ready  = rd_a[t2];
            bus.num_blocks = (t2 == 0) ? W'(nb) : W'($urandom);
            expect_at(t2, nblk, done_t, e, eb);
            #1;
            chk("outputs", t2, obs_vec(), e);
            if (e[12]) chk("blk_idx", t2, bus.blk_idx, eb);
            chk("wen_exclusive", t2, bus.wen_temp & bus.wen_out, 0);
            nwt += int'(bus.wen_temp);
            nwo += int'(bus.wen_out);
            if (t2 == t_rst) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk("async_reset", t2, obs_vec(), 13'd0);
                chk("async_reset_blk", t2, bus.blk_idx, 0);
                bus.start = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                reset_release();
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (t_ab < 0 && t_rst < 0) begin
            chk("wen_temp_total", end_t, nwt, 64 * nblk);
            chk("wen_out_total", end_t, nwo, 64 * nblk);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.num_blocks = '0;
        bus.abort      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", -1, obs_vec(), 13'd0);
        chk("reset_blk", -1, bus.blk_idx, 0);
        reset_release();

        run(1, -1, 0, 0, -1, 0, -1);   // single block, full throughput
        run(1, -1, 0, 1, -1, 0, -1);   // PASS2 back-pressure, ready 0,1,0,1...
        run(3, 2, 10, 0, -1, 0, -1);   // starvation before the third block
        run(0, -1, 0, 2, -1, 0, -1);   // zero count -> 2^W blocks
        run(1, -1, 0, 2, 0, 29, -1);   // abort at PASS2 (3,5)
        run(2, -1, 0, 2, -1, 0, -1);   // restart straight after abort
        run(2, -1, 0, 2, -1, 0, 18);   // reset at PASS1 (2,2)
        run(1, -1, 0, 0, -1, 0, -1);
        for (int r = 0; r < 3; r++) begin
            run(int'($urandom_range(NMAX - 1)), int'($urandom_range(NMAX - 1)),
                int'($urandom_range(15)), 2, -1, 0, -1);
        end

        for (int q = 0; q < 4; q++) begin
            bus.start = 1'b0;
            bus.abort = 1'b0;
            #1;
            chk("final_idle", q, obs_vec(), 13'd0);
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
